// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer: FSM states,
// the per-stage control word and its canned values.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2
  } state_e;

  localparam logic [4:0] RegX0 = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CtrlAdvance = '{
    pc_en: 1'b1, pc_redirect: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b0,
    idex_en: 1'b1, idex_bubble: 1'b0, exmem_en: 1'b1, memwb_bubble: 1'b0
  };

  localparam ctrl_t CtrlReset = '{
    pc_en: 1'b0, pc_redirect: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
    idex_en: 1'b0, idex_bubble: 1'b1, exmem_en: 1'b0, memwb_bubble: 1'b1
  };

  // Whole pipe frozen; only MEM/WB advances, carrying a bubble.
  localparam ctrl_t CtrlFreeze = '{
    pc_en: 1'b0, pc_redirect: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
    idex_en: 1'b0, idex_bubble: 1'b0, exmem_en: 1'b0, memwb_bubble: 1'b1
  };

  localparam ctrl_t CtrlRedirect = '{
    pc_en: 1'b1, pc_redirect: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
    idex_en: 1'b1, idex_bubble: 1'b1, exmem_en: 1'b1, memwb_bubble: 1'b0
  };

  // Front end holds; ID/EX still clocks so the bubble is inserted behind the load.
  localparam ctrl_t CtrlLuStall = '{
    pc_en: 1'b0, pc_redirect: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
    idex_en: 1'b1, idex_bubble: 1'b1, exmem_en: 1'b1, memwb_bubble: 1'b0
  };

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-state inputs and stage-control outputs of the hazard sequencer.
// master = pipeline datapath side, slave = the sequencer.
interface pipe_hazard_ctrl_if;

  logic [4:0]  ra1_ID;
  logic [4:0]  ra2_ID;
  logic        use_rs1_ID;
  logic        use_rs2_ID;
  logic        memread_EX;
  logic [4:0]  wa_EX;
  logic        br_taken_EX;
  logic        dmem_req_MEM;
  logic        dmem_ready;

  logic        pc_en;
  logic        pc_redirect;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_bubble;
  logic        exmem_en;
  logic        memwb_bubble;
  logic        err_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] wait_cnt;

  modport master (
    output ra1_ID, ra2_ID, use_rs1_ID, use_rs2_ID, memread_EX, wa_EX,
    output br_taken_EX, dmem_req_MEM, dmem_ready,
    input  pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble,
    input  exmem_en, memwb_bubble, err_timeout, stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  ra1_ID, ra2_ID, use_rs1_ID, use_rs2_ID, memread_EX, wa_EX,
    input  br_taken_EX, dmem_req_MEM, dmem_ready,
    output pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble,
    output exmem_en, memwb_bubble, err_timeout, stall_cnt, flush_cnt, wait_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. x0 never hazards.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] ra1_i,
  input  logic [4:0] ra2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  input  logic       memread_i,
  input  logic [4:0] wa_i,
  output logic       lu_hazard_o
);

  logic rs1_match;
  logic rs2_match;

  always_comb begin
    rs1_match   = use_rs1_i && (ra1_i == wa_i);
    rs2_match   = use_rs2_i && (ra2_i == wa_i);
    lu_hazard_o = memread_i && (wa_i != RegX0) && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: Mealy FSM driving stage enables and flush/bubble strobes.
// Optional perf counters are built only when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_STALL_CYC = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned LuW        = (LU_STALL_CYC > 2) ? $clog2(LU_STALL_CYC) : 1;
  localparam logic [7:0]  TimeoutCmp = 8'(MEM_TIMEOUT);

  state_e         state_q, state_d;
  logic [LuW-1:0] lu_cnt_q, lu_cnt_d;
  logic [7:0]     wait8_q, wait8_d;
  logic           err_q, err_d;
  logic           lu_hazard;
  logic           mem_wait;
  ctrl_t          ctrl;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .ra1_i       (bus.ra1_ID),
    .ra2_i       (bus.ra2_ID),
    .use_rs1_i   (bus.use_rs1_ID),
    .use_rs2_i   (bus.use_rs2_ID),
    .memread_i   (bus.memread_EX),
    .wa_i        (bus.wa_EX),
    .lu_hazard_o (lu_hazard)
  );

  assign mem_wait = bus.dmem_req_MEM && !bus.dmem_ready;

  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    wait8_d  = '0;
    ctrl     = CtrlAdvance;
    if (mem_wait) begin
      // A pending branch or load-use is simply re-seen once the pipe moves again.
      ctrl    = CtrlFreeze;
      state_d = StMemWait;
      wait8_d = (wait8_q == 8'hFF) ? wait8_q : wait8_q + 8'd1;
    end else if (bus.br_taken_EX) begin
      ctrl    = CtrlRedirect;
      state_d = StRun;
    end else if (state_q == StLuStall) begin
      ctrl     = CtrlLuStall;
      lu_cnt_d = lu_cnt_q - LuW'(1);
      if (lu_cnt_q == LuW'(1)) begin
        state_d = StRun;
      end
    end else if (lu_hazard) begin
      ctrl = CtrlLuStall;
      if (LU_STALL_CYC > 1) begin
        state_d  = StLuStall;
        lu_cnt_d = LuW'(LU_STALL_CYC - 1);
      end else begin
        state_d = StRun;
      end
    end else begin
      state_d = StRun;
    end
    if (!rst_n) begin
      ctrl = CtrlReset;
    end
  end

  // Timeout flag rises in the same cycle the counter reaches the threshold.
  assign err_d = err_q || (mem_wait && (wait8_d == TimeoutCmp));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StRun;
      lu_cnt_q <= '0;
      wait8_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      wait8_q  <= wait8_d;
      err_q    <= err_d;
    end
  end

  assign bus.pc_en        = ctrl.pc_en;
  assign bus.pc_redirect  = ctrl.pc_redirect;
  assign bus.ifid_en      = ctrl.ifid_en;
  assign bus.ifid_flush   = ctrl.ifid_flush;
  assign bus.idex_en      = ctrl.idex_en;
  assign bus.idex_bubble  = ctrl.idex_bubble;
  assign bus.exmem_en     = ctrl.exmem_en;
  assign bus.memwb_bubble = ctrl.memwb_bubble;
  assign bus.err_timeout  = err_q;

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] wait_cnt_q;
  logic        stall_ev;

  assign stall_ev = (ctrl == CtrlLuStall);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (stall_ev)         stall_cnt_q <= sat_inc32(stall_cnt_q);
      if (ctrl.pc_redirect) flush_cnt_q <= sat_inc32(flush_cnt_q);
      if (mem_wait)         wait_cnt_q  <= sat_inc32(wait_cnt_q);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.wait_cnt  = wait_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
  assign bus.wait_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: two instances (LU_STALL_CYC 1/2,
// MEM_TIMEOUT 255/4) share stimulus and are checked against a cycle model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] ra1 = '0, ra2 = '0, wa = '0;
  logic       u1 = 1'b0, u2 = 1'b0, mr = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, one slot per DUT.
  int          lu_cyc[2]   = '{1, 2};
  int          tmo[2]      = '{255, 4};
  int          lu_rem[2]   = '{0, 0};
  int          wait_run[2] = '{0, 0};
  bit          err_m[2]    = '{1'b0, 1'b0};
  int unsigned st_m[2]     = '{0, 0};
  int unsigned fl_m[2]     = '{0, 0};
  int unsigned wt_m[2]     = '{0, 0};

  string sig_names[9] = '{"pc_en", "pc_redirect", "ifid_en", "ifid_flush", "idex_en",
                          "idex_bubble", "exmem_en", "memwb_bubble", "err_timeout"};

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if if_a ();
  pipe_hazard_ctrl_if if_b ();

  assign if_a.ra1_ID = ra1;       assign if_b.ra1_ID = ra1;
  assign if_a.ra2_ID = ra2;       assign if_b.ra2_ID = ra2;
  assign if_a.use_rs1_ID = u1;    assign if_b.use_rs1_ID = u1;
  assign if_a.use_rs2_ID = u2;    assign if_b.use_rs2_ID = u2;
  assign if_a.memread_EX = mr;    assign if_b.memread_EX = mr;
  assign if_a.wa_EX = wa;         assign if_b.wa_EX = wa;
  assign if_a.br_taken_EX = br;   assign if_b.br_taken_EX = br;
  assign if_a.dmem_req_MEM = req; assign if_b.dmem_req_MEM = req;
  assign if_a.dmem_ready = rdy;   assign if_b.dmem_ready = rdy;

  pipe_hazard_ctrl #(.LU_STALL_CYC(1), .MEM_TIMEOUT(255)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  pipe_hazard_ctrl #(.LU_STALL_CYC(2), .MEM_TIMEOUT(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Compare one DUT's outputs against the model, then advance the model by one clock.
  task automatic model_step(input int k, input logic [8:0] got, input logic [31:0] g_st,
                            input logic [31:0] g_fl, input logic [31:0] g_wt);
    bit         hz, wt;
    logic [8:0] exp;
    string      nm;
    nm = (k == 0) ? "A" : "B";
    hz = mr && (wa != 5'd0) && ((u1 && ra1 == wa) || (u2 && ra2 == wa));
    wt = req && !rdy;
    if (!rst_n)                      exp = {8'b0001_0101, err_m[k]};
    else if (wt)                     exp = {8'b0000_0001, err_m[k]};
    else if (br)                     exp = {8'b1111_1110, err_m[k]};
    else if (lu_rem[k] > 0 || hz)    exp = {8'b0000_1110, err_m[k]};
    else                             exp = {8'b1010_1010, err_m[k]};
    for (int i = 0; i < 9; i++) begin
      check({nm, ".", sig_names[i]}, 32'(got[8-i]), 32'(exp[8-i]));
    end
`ifdef HAZ_PERF_EN
    check({nm, ".stall_cnt"}, g_st, st_m[k]);
    check({nm, ".flush_cnt"}, g_fl, fl_m[k]);
    check({nm, ".wait_cnt"},  g_wt, wt_m[k]);
`else
    check({nm, ".stall_cnt"}, g_st, 32'd0);
    check({nm, ".flush_cnt"}, g_fl, 32'd0);
    check({nm, ".wait_cnt"},  g_wt, 32'd0);
`endif
    if (!rst_n) begin
      lu_rem[k] = 0; wait_run[k] = 0; err_m[k] = 1'b0;
      st_m[k] = 0;   fl_m[k] = 0;     wt_m[k] = 0;
    end else if (wt) begin
      lu_rem[k] = 0;
      if (wait_run[k] < 255) wait_run[k]++;
      if (wait_run[k] == tmo[k]) err_m[k] = 1'b1;
      wt_m[k]++;
    end else begin
      wait_run[k] = 0;
      if (br) begin
        lu_rem[k] = 0;
        fl_m[k]++;
      end else if (lu_rem[k] > 0) begin
        lu_rem[k]--;
        st_m[k]++;
      end else if (hz) begin
        lu_rem[k] = lu_cyc[k] - 1;
        st_m[k]++;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                     input logic e1, input logic e2, input logic m, input logic [4:0] w,
                     input logic b, input logic q, input logic y);
    @(posedge clk);
    #1;
    rst_n = r; ra1 = a1; ra2 = a2; u1 = e1; u2 = e2; mr = m; wa = w;
    br = b; req = q; rdy = y;
    #3;
    model_step(0, {if_a.pc_en, if_a.pc_redirect, if_a.ifid_en, if_a.ifid_flush,
                   if_a.idex_en, if_a.idex_bubble, if_a.exmem_en, if_a.memwb_bubble,
                   if_a.err_timeout}, if_a.stall_cnt, if_a.flush_cnt, if_a.wait_cnt);
    model_step(1, {if_b.pc_en, if_b.pc_redirect, if_b.ifid_en, if_b.ifid_flush,
                   if_b.idex_en, if_b.idex_bubble, if_b.exmem_en, if_b.memwb_bubble,
                   if_b.err_timeout}, if_b.stall_cnt, if_b.flush_cnt, if_b.wait_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // First edge initialises the flops; checking starts afterwards.
    @(posedge clk);
    // Reset held, then release.
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Load-use via rs2.
    cyc(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Load to x0, and unused rs2: no stall.
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Branch together with load-use.
    cyc(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    idle(1);
    // Branch arriving during the second stall cycle of dut_b.
    cyc(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Three wait cycles with a pending branch, then ready.
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle(1);
    // Timeout on dut_b, then reset mid-wait.
    for (int i = 0; i < 7; i++) cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Long wait reaches the 255 threshold and saturation on dut_a.
    for (int i = 0; i < 262; i++) cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Random traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 99) != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 40),
          1'($urandom_range(0, 99) < 60));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
